// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences one dot-product job through an external combinational
// dual-lane 16x16 signed MAC (a0*b0 + a1*b1 + csum_in) and presents the 32-bit
// sum on a valid/ready result port.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, cfg_beats, cfg_keep  job launch (honoured only in IDLE); beat count; keep-acc flag
//   abort                       synchronous cancel in RUN/DONE (acc kept)
//   busy                        high in RUN or DONE
//   in_valid/in_ready           operand beat handshake
//   ain0, ain1, bin0, bin1      signed lane operands
//   mac_ain0/1, mac_bin0/1      operands to the MAC (zero unless a beat is accepted)
//   mac_csum_in/mac_csum_out    running sum to/from the MAC
//   res_valid/res_ready         result handshake
//   res_data                    signed 32-bit dot product (wraps modulo 2^32)
module mac_dot_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_beats,
  input  logic             cfg_keep,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      ain0,
  input  logic [15:0]      ain1,
  input  logic [15:0]      bin0,
  input  logic [15:0]      bin1,
  output logic [15:0]      mac_ain0,
  output logic [15:0]      mac_ain1,
  output logic [15:0]      mac_bin0,
  output logic [15:0]      mac_bin1,
  output logic [31:0]      mac_csum_in,
  input  logic [31:0]      mac_csum_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic             beat_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // abort wins over a presented beat, so in_ready is withheld in that cycle.
  assign in_ready  = (state_q == RUN) && !abort;
  assign beat_acc  = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_valid ? acc_q : '0;

  // Operands reach the MAC only on an accepted beat; the MAC is combinational,
  // so its output is captured into acc in the same cycle.
  assign mac_ain0    = beat_acc ? ain0 : '0;
  assign mac_ain1    = beat_acc ? ain1 : '0;
  assign mac_bin0    = beat_acc ? bin0 : '0;
  assign mac_bin1    = beat_acc ? bin1 : '0;
  assign mac_csum_in = acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = cfg_keep ? acc_q : '0;
          cnt_d   = cfg_beats;
          state_d = (cfg_beats != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (beat_acc) begin
          acc_d = mac_csum_out;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Testbench for mac_dot_seq: directed jobs followed by randomized jobs, with an
// expected-result queue filled by the stimulus side and drained by a monitor.
module tb_mac_dot_seq;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_beats = '0;
  logic             cfg_keep = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      ain0 = '0, ain1 = '0, bin0 = '0, bin1 = '0;
  logic [15:0]      mac_ain0, mac_ain1, mac_bin0, mac_bin1;
  logic [31:0]      mac_csum_in, mac_csum_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;

  mac_dot_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_beats(cfg_beats),
    .cfg_keep(cfg_keep), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .ain0(ain0), .ain1(ain1), .bin0(bin0), .bin1(bin1),
    .mac_ain0(mac_ain0), .mac_ain1(mac_ain1), .mac_bin0(mac_bin0), .mac_bin1(mac_bin1),
    .mac_csum_in(mac_csum_in), .mac_csum_out(mac_csum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // External combinational MAC.
  logic signed [31:0] p0, p1;
  assign p0 = $signed(mac_ain0) * $signed(mac_bin0);
  assign p1 = $signed(mac_ain1) * $signed(mac_bin1);
  assign mac_csum_out = mac_csum_in + p0 + p1;

  always #5 clk = ~clk;

  typedef struct {
    shortint a0, a1, b0, b1;
  } beat_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_acc = '0;
  logic [31:0] exp_q[$];
  beat_t       beats[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dot(input beat_t b);
    int s;
    s = int'(b.a0) * int'(b.b0) + int'(b.a1) * int'(b.b1);
    return s;
  endfunction

  // Monitor: compare the held result every cycle it is valid, retire on handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL res_unexpected: got %0h expected no result", res_data);
      end else begin
        check("res_data", res_data, exp_q[0]);
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic add_beat(input shortint a0, input shortint a1, input shortint b0, input shortint b1);
    beat_t b;
    b.a0 = a0; b.a1 = a1; b.b0 = b0; b.b1 = b1;
    beats.push_back(b);
  endtask

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic do_start(input int n, input bit keep);
    start = 1'b1; cfg_beats = CNT_W'(n); cfg_keep = keep;
    @(posedge clk); #1;
    start = 1'b0; cfg_beats = CNT_W'($urandom); cfg_keep = 1'($urandom);
    if (!keep) model_acc = '0;
  endtask

  task automatic gap_cycle();
    in_valid = 1'b0;
    ain0 = 16'($urandom); ain1 = 16'($urandom); bin0 = 16'($urandom); bin1 = 16'($urandom);
    @(negedge clk);
    check("in_ready_gap", {31'b0, in_ready}, 32'd1);
    check("mac_gated", {mac_ain0, mac_bin1}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input beat_t b);
    int i;
    in_valid = 1'b1;
    ain0 = b.a0; ain1 = b.a1; bin0 = b.b0; bin1 = b.b1;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("in_ready_beat", {31'b0, in_ready}, 32'd1);
    check("mac_csum_in", mac_csum_in, model_acc);
    check("mac_ops", {mac_ain0, mac_bin1}, {b.a0, b.b1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_acc = model_acc + dot(b);
  endtask

  task automatic wait_result(input int stall, input bit start_in_stall);
    int i;
    res_ready = (stall == 0);
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("res_latency", i, 0);
    @(posedge clk); #1;
    if (stall > 0) begin
      start = start_in_stall; cfg_beats = '0; cfg_keep = 1'b0;
      repeat (stall - 1) begin @(posedge clk); #1; end
      res_ready = 1'b1;
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_hs", {31'b0, busy}, 32'd0);
    check("valid_after_hs", {31'b0, res_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int n, input bit keep, input int gap, input int stall, input bit sis);
    do_start(n, keep);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) gap_cycle();
      send_beat(beats[i]);
    end
    exp_q.push_back(model_acc);
    wait_result(stall, sis);
  endtask

  task automatic load_t1();
    beats.delete();
    add_beat(1, 2, 3, 4);
    add_beat(-5, 6, 7, 8);
    add_beat(100, -2, 3, 3);
  endtask

  initial begin
    #1;
    start = 1'b1; in_valid = 1'b1; ain0 = 16'h1234; bin0 = 16'h0042;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_mac_ops", {mac_ain0, mac_bin0}, 32'd0);
    check("rst_csum_in", mac_csum_in, 32'd0);
    start = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 / T2 / T3
    load_t1();
    run_job(3, 1'b0, 0, 0, 1'b0);
    run_job(3, 1'b0, 2, 0, 1'b0);
    run_job(3, 1'b0, 0, 5, 1'b1);

    // T4: chaining via keep
    beats.delete(); add_beat(1, 0, 1, 0);
    run_job(1, 1'b1, 0, 0, 1'b0);
    run_job(0, 1'b1, 0, 2, 1'b0);
    run_job(0, 1'b0, 0, 0, 1'b0);

    // T5: wrap
    beats.delete();
    add_beat(-32768, -32768, -32768, -32768);
    add_beat(-32768, -32768, -32768, -32768);
    run_job(1, 1'b0, 0, 0, 1'b0);
    run_job(2, 1'b0, 0, 0, 1'b0);

    // T6: abort after the first beat, with a beat presented in the abort cycle
    load_t1();
    do_start(3, 1'b0);
    send_beat(beats[0]);
    abort = 1'b1; in_valid = 1'b1;
    ain0 = 16'd7; ain1 = 16'd7; bin0 = 16'd7; bin1 = 16'd7;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    check("abort_mac_gated", {mac_ain0, mac_bin0}, 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_no_valid", {31'b0, res_valid}, 32'd0);
    end
    @(posedge clk); #1;
    // abort keeps the partial sum: an empty keep job returns it
    run_job(0, 1'b1, 0, 0, 1'b0);

    // Async reset mid-RUN
    do_start(3, 1'b0);
    send_beat(beats[0]);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd0);
    check("arst_res_valid", {31'b0, res_valid}, 32'd0);
    check("arst_csum_in", mac_csum_in, 32'd0);
    model_acc = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    beats.delete(); add_beat(1, 0, 1, 0);
    run_job(1, 1'b1, 0, 0, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 6);
      beats.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0)
          add_beat(-32768, shortint'($urandom), -32768, 32767);
        else
          add_beat(shortint'($urandom), shortint'($urandom), shortint'($urandom), shortint'($urandom));
      end
      run_job(n, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    check("results_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
